shift_sequencer: RTL

//  Multi-cycle controller that executes ARM register-specified shifts (8-bit amount, 0..255) on the
//  32-bit combinational `shifter`, which it instantiates internally. The `shifter` handles only 5-bit amounts.
//  The controller splits the amount into chunks of at most STEP_MAX, one chunk per cycle.
//  It computes the ARM shifter carry-out itself and returns the result over a valid/ready handshake.

---
 rtl/shift_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle ARM register-specified shift controller
// Splits 8-bit shift amounts into chunks of at most STEP_MAX bits for a 5-bit combinational shifter.

module shifter (
    input  logic [31:0] i_value,
    input  logic [4:0]  i_shift,
    input  logic [2:0]  i_opcode,
    input  logic        i_carry,
    output logic [31:0] o_result,
    output logic        o_carry
);
    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_RRX = 3'd4;

    always_comb begin
        o_result = i_value;
        o_carry  = i_carry;
        case (i_opcode)
            OP_LSL: o_result = i_value << i_shift;
            OP_LSR: o_result = i_value >> i_shift;
            OP_ASR: o_result = 32'($signed(i_value) >>> i_shift);
            OP_ROR: o_result = (i_value >> i_shift) | (i_value << (6'd32 - {1'b0, i_shift}));
            OP_RRX: begin
                o_result = {i_carry, i_value[31:1]};
                o_carry  = i_value[0];
            end
            default: ;
        endcase
    end
endmodule

module shift_sequencer #(
    parameter int STEP_MAX = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_opcode,
    input  logic [31:0] req_operand,
    input  logic [7:0]  req_amount,
    input  logic        req_carry,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_carry,
    output logic        busy
);
    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_RRX = 3'd4;
    localparam logic [5:0] STEP   = 6'(STEP_MAX);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_work, w_work_nxt;
    logic        r_carry, w_carry_nxt;
    logic [2:0]  r_op, w_op_nxt;
    logic [5:0]  r_rem, w_rem_nxt;
    logic        r_ident, w_ident_nxt;

    logic [5:0]  w_e;
    logic        w_id_req;
    logic [5:0]  w_k;
    logic [31:0] w_sh_result;
    logic        w_sh_carry;
    logic        w_chunk_carry;

    assign w_k = (r_rem > STEP) ? STEP : r_rem;

    shifter u_shifter (
        .i_value  (r_work),
        .i_shift  (w_k[4:0]),
        .i_opcode (r_op),
        .i_carry  (r_carry),
        .o_result (w_sh_result),
        .o_carry  (w_sh_carry)
    );

    // Saturate the amount so a 255-bit shift still finishes in two chunks.
    always_comb begin
        w_e      = 6'd0;
        w_id_req = 1'b0;
        case (req_opcode)
            OP_LSL, OP_LSR: w_e = (req_amount > 8'd33) ? 6'd33 : req_amount[5:0];
            OP_ASR:         w_e = (req_amount > 8'd32) ? 6'd32 : req_amount[5:0];
            OP_ROR: begin
                w_e      = {1'b0, req_amount[4:0]};
                w_id_req = (req_amount != 8'd0) && (req_amount[4:0] == 5'd0);
            end
            OP_RRX:         w_e = 6'd1;
            default: ;
        endcase
    end

    always_comb begin
        w_chunk_carry = w_sh_carry;
        case (r_op)
            OP_LSL:         w_chunk_carry = r_work[5'(6'd32 - w_k)];
            OP_LSR, OP_ASR: w_chunk_carry = r_work[5'(w_k - 6'd1)];
            OP_ROR:         w_chunk_carry = w_sh_result[31];
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_carry_nxt = r_carry;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;
        w_ident_nxt = r_ident;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_work_nxt  = req_operand;
                    w_carry_nxt = req_carry;
                    w_op_nxt    = req_opcode;
                    w_rem_nxt   = w_e;
                    w_ident_nxt = w_id_req;
                    w_state_nxt = (w_e == 6'd0 && !w_id_req) ? S_RESP : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_ident) begin
                    w_carry_nxt = r_work[31];
                    w_ident_nxt = 1'b0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_work_nxt  = w_sh_result;
                    w_carry_nxt = w_chunk_carry;
                    w_rem_nxt   = r_rem - w_k;
                    if (r_rem == w_k) w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_work  <= 32'd0;
            r_carry <= 1'b0;
            r_op    <= 3'd0;
            r_rem   <= 6'd0;
            r_ident <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_carry <= w_carry_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
            r_ident <= w_ident_nxt;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign rsp_result = r_work;
    assign rsp_carry  = r_carry;
endmodule
